modn_updown_counter: RTL and testbench
======================================

Name: modn_updown_counter

Overview:
- Synchronous, parametrised modulo-N counter with up/down counting and enable.
- Adds synchronous clear, parallel load with range check, a terminal-count output for cascading, and a wrap-event counter.
- Successor to the fixed-width mod-14 ripple counter. All flops share one clock, so decode is glitch-free.
- Used as a general timebase/divider. Instances cascade through tc into the next stage's en.

Parameters:
- WIDTH, 4: counter width in bits.
- MODULUS, 14: count range is 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; elaboration-time check fails otherwise.
- RESET_VAL, 0: value of count after rstn. Must be < MODULUS.
- WRAP_W, 8: width of the wrap-event counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  reset, asynchronous, active-low.
- en  in  1  count enable; one step per enabled cycle.
- up  in  1  direction: 1 = increment, 0 = decrement.
- sclr  in  1  synchronous clear to 0.
- ld  in  1  synchronous parallel load.
- ld_val  in  WIDTH  load value.
- count  out  WIDTH  current count (registered).
- tc  out  1  terminal count, combinational: en & ((up & count==MODULUS-1) | (!up & count==0)).
- wrap  out  1  registered one-cycle pulse, the cycle after a wrap occurred.
- ld_err  out  1  registered one-cycle pulse, the cycle after a load with ld_val >= MODULUS.
- wrap_cnt  out  WRAP_W  number of wraps since reset or sclr; saturates at all-ones.

Behaviour:
- Reset (rstn low, async): count=RESET_VAL, wrap=0, ld_err=0, wrap_cnt=0. Reset takes effect mid-count immediately, regardless of en, ld or sclr.
- Per-cycle priority: sclr > ld > en > hold.
- sclr:
  - count=0, wrap_cnt=0, wrap=0, ld_err=0.
  - ld and en are ignored that cycle.
- ld (sclr=0):
  - If ld_val < MODULUS: count=ld_val.
  - Otherwise: count=MODULUS-1 (clamped) and ld_err=1 next cycle.
  - en is ignored that cycle; no wrap is generated by a load.
- en (sclr=0, ld=0):
  - up=1: count = (count==MODULUS-1) ? 0 : count+1.
  - up=0: count = (count==0) ? MODULUS-1 : count-1.
  - A wrap is the tc==1 step. It sets wrap=1 for the next cycle and increments wrap_cnt, which saturates at 2**WRAP_W-1 without rolling over.
- en=0: count holds; tc=0.
- Direction change takes effect on the same edge as the step; no pipeline.
- MODULUS == 2**WIDTH: natural binary roll-over; the comparison logic still applies.
- Latency:
  - count updates one cycle after the controlling input is sampled.
  - tc is zero-latency from count/en/up.
  - wrap and ld_err are coincident with the count value after the wrap or load.
- Out-of-range count (unreachable after reset): on the next en step, count is treated as terminal and wraps, so the counter self-recovers.
- No combinational path from ld_val to any output.

Decomposition:
- Shared package: direction constants (DIR_UP=1, DIR_DOWN=0) and a function computing the next value (count, up, MODULUS). Bench and RTL reuse this function.
- One natural sub-module, sat_counter: a saturating WRAP_W-bit event counter with inc and clr inputs. It also serves other blocks.
- The counter core stays flat.

Test Plan (defaults WIDTH=4, MODULUS=14):
1. Reset and up-count: rstn low 4 cycles, then en=1, up=1 for 30 cycles -> count 0,1,..,13,0,..; tc high exactly when count=13; wrap pulses after 13->0; wrap_cnt=2 after 28 steps.
2. Down-count and direction change: ld 3, then en=1, up=0 -> 2,1,0,13 with wrap pulse. Set up=1 at count=13 -> next value 0 with wrap. Then toggle up=0 at count=5 -> 4 on that edge.
3. Load range: ld_val=9 -> count=9, ld_err=0. ld_val=15 -> count=13, ld_err=1 for exactly one cycle. ld with en=1 at count=13 -> no wrap pulse.
4. Priority and enable: sclr=ld=en=1 with count=7 and wrap_cnt=5 -> count=0, wrap_cnt=0. en=0 for 10 cycles -> count holds, tc=0.
5. Saturation and reset mid-operation: WRAP_W=2, run 5 full wraps -> wrap_cnt stays 3. Assert rstn low asynchronously between edges at count=6 -> count=0 immediately, no wrap pulse.
6. Parameter sweep: MODULUS=16, WIDTH=4 -> clean 15->0 roll-over with tc. MODULUS=2, RESET_VAL=1 -> count alternates 1,0,1 with a wrap on every step.

Source files
------------

// File: rtl/modn_updown_counter_pkg.sv
// Shared constants and next-value arithmetic for the modulo-N up/down counter.
package modn_updown_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // A count at or beyond the top of the range is treated as terminal so that
  // an out-of-range value recovers on the next enabled step.
  function automatic logic is_terminal(input int unsigned count,
                                       input logic        up,
                                       input int unsigned modulus);
    if (up == DIR_UP) return (count >= modulus - 1);
    else              return (count == 0) || (count >= modulus);
  endfunction

  // Value after one enabled step in the given direction.
  function automatic int unsigned next_count(input int unsigned count,
                                             input logic        up,
                                             input int unsigned modulus);
    if (is_terminal(count, up, modulus)) begin
      return (up == DIR_UP) ? 0 : modulus - 1;
    end
    return (up == DIR_UP) ? count + 1 : count - 1;
  endfunction

endpackage

// File: rtl/modn_updown_counter_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, clr wins.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Event count register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with clear, range-checked load, terminal count for
// cascading into the next stage's enable, and a saturating wrap counter.
module modn_updown_counter
  import modn_updown_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 14,
  parameter int RESET_VAL = 0,
  parameter int WRAP_W    = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              up,
  input  logic              sclr,
  input  logic              ld,
  input  logic [WIDTH-1:0]  ld_val,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              wrap,
  output logic              ld_err,
  output logic [WRAP_W-1:0] wrap_cnt
);

  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
    $error("modn_updown_counter: MODULUS must lie in 2..2**WIDTH");
  end
  if ((RESET_VAL < 0) || (RESET_VAL >= MODULUS)) begin : g_bad_reset_val
    $error("modn_updown_counter: RESET_VAL must be below MODULUS");
  end

  localparam int unsigned      MOD_U   = MODULUS;
  localparam logic [WIDTH-1:0] MOD_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ld_err_q, ld_err_d;
  logic             at_term;

  assign at_term = is_terminal(32'(count_q), up, MOD_U);

  // Next-state selection with priority sclr > ld > en > hold; a wrap is
  // only ever produced by an enabled step, never by a load.
  always_comb begin
    count_d  = count_q;
    wrap_d   = 1'b0;
    ld_err_d = 1'b0;
    if (sclr) begin
      count_d = '0;
    end else if (ld) begin
      if (32'(ld_val) < MOD_U) begin
        count_d = ld_val;
      end else begin
        count_d  = MOD_MAX;
        ld_err_d = 1'b1;
      end
    end else if (en) begin
      count_d = WIDTH'(next_count(32'(count_q), up, MOD_U));
      wrap_d  = at_term;
    end
  end

  // Count and pulse registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q  <= RST_CNT;
      wrap_q   <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      ld_err_q <= ld_err_d;
    end
  end

  sat_counter #(
    .W(WRAP_W)
  ) u_wrap_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr_i(sclr),
    .inc_i(wrap_d),
    .cnt_o(wrap_cnt)
  );

  assign count  = count_q;
  assign tc     = en & at_term;
  assign wrap   = wrap_q;
  assign ld_err = ld_err_q;

endmodule

// File: tb/tb_modn_updown_counter.sv
module tb_modn_updown_counter;

  logic       clk = 1'b0;
  logic       rstn, en, up, sclr, ld;
  logic [3:0] ld_val;

  logic [3:0] c_a;  logic tc_a, wrap_a, lderr_a; logic [7:0] wcnt_a;
  logic [3:0] c_s;  logic tc_s, wrap_s, lderr_s; logic [1:0] wcnt_s;
  logic [3:0] c_m;  logic tc_m, wrap_m, lderr_m; logic [7:0] wcnt_m;
  logic [3:0] c_2;  logic tc_2, wrap_2, lderr_2; logic [7:0] wcnt_2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  modn_updown_counter #(.WIDTH(4), .MODULUS(14), .RESET_VAL(0), .WRAP_W(8)) dut_a (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .sclr(sclr), .ld(ld), .ld_val(ld_val),
    .count(c_a), .tc(tc_a), .wrap(wrap_a), .ld_err(lderr_a), .wrap_cnt(wcnt_a));

  modn_updown_counter #(.WIDTH(4), .MODULUS(14), .RESET_VAL(0), .WRAP_W(2)) dut_s (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .sclr(sclr), .ld(ld), .ld_val(ld_val),
    .count(c_s), .tc(tc_s), .wrap(wrap_s), .ld_err(lderr_s), .wrap_cnt(wcnt_s));

  modn_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0), .WRAP_W(8)) dut_m (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .sclr(sclr), .ld(ld), .ld_val(ld_val),
    .count(c_m), .tc(tc_m), .wrap(wrap_m), .ld_err(lderr_m), .wrap_cnt(wcnt_m));

  modn_updown_counter #(.WIDTH(4), .MODULUS(2), .RESET_VAL(1), .WRAP_W(8)) dut_2 (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .sclr(sclr), .ld(ld), .ld_val(ld_val),
    .count(c_2), .tc(tc_2), .wrap(wrap_2), .ld_err(lderr_2), .wrap_cnt(wcnt_2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0; en = 1'b0; up = 1'b1; sclr = 1'b0; ld = 1'b0; ld_val = '0;
    repeat (4) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b1; up = 1'b1; sclr = 1'b0; ld = 1'b0; ld_val = '0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (c_a !== 4'd0) $display("FAIL reset_count got %0d want 0", c_a); else passed++;
    total++; if (wrap_a !== 1'b0) $display("FAIL reset_wrap got %0b want 0", wrap_a); else passed++;
    total++; if (lderr_a !== 1'b0) $display("FAIL reset_lderr got %0b want 0", lderr_a); else passed++;
    total++; if (wcnt_a !== 8'd0) $display("FAIL reset_wcnt got %0d want 0", wcnt_a); else passed++;
    total++; if (c_2 !== 4'd1) $display("FAIL reset_val_mod2 got %0d want 1", c_2); else passed++;
    rstn = 1'b1; en = 1'b0;
  endtask

  task automatic test_up_count();
    int  exp_c = 0;
    int  wraps = 0;
    logic wr;
    apply_reset();
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 30; i++) begin
      #1;
      total++; if (tc_a !== (exp_c == 13)) $display("FAIL up_tc step %0d got %0b want %0b", i, tc_a, (exp_c == 13)); else passed++;
      tick();
      wr = (exp_c == 13);
      exp_c = (exp_c + 1) % 14;
      if (wr) wraps++;
      total++; if (c_a !== 4'(exp_c)) $display("FAIL up_count step %0d got %0d want %0d", i, c_a, exp_c); else passed++;
      total++; if (wrap_a !== wr) $display("FAIL up_wrap step %0d got %0b want %0b", i, wrap_a, wr); else passed++;
      total++; if (wcnt_a !== 8'(wraps)) $display("FAIL up_wcnt step %0d got %0d want %0d", i, wcnt_a, wraps); else passed++;
    end
    total++; if (wcnt_a !== 8'd2) $display("FAIL up_wcnt_final got %0d want 2", wcnt_a); else passed++;
    en = 1'b0;
  endtask

  task automatic test_down_dir();
    int   exp_seq[4] = '{2, 1, 0, 13};
    logic wr_seq[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    ld = 1'b1; ld_val = 4'd3;
    tick();
    total++; if (c_a !== 4'd3) $display("FAIL down_load got %0d want 3", c_a); else passed++;
    ld = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (c_a !== 4'(exp_seq[i])) $display("FAIL down_count step %0d got %0d want %0d", i, c_a, exp_seq[i]); else passed++;
      total++; if (wrap_a !== wr_seq[i]) $display("FAIL down_wrap step %0d got %0b want %0b", i, wrap_a, wr_seq[i]); else passed++;
    end
    up = 1'b1;
    #1;
    total++; if (tc_a !== 1'b1) $display("FAIL dir_tc_at13 got %0b want 1", tc_a); else passed++;
    tick();
    total++; if (c_a !== 4'd0) $display("FAIL dir_up_wrap_count got %0d want 0", c_a); else passed++;
    total++; if (wrap_a !== 1'b1) $display("FAIL dir_up_wrap_pulse got %0b want 1", wrap_a); else passed++;
    repeat (5) tick();
    total++; if (c_a !== 4'd5) $display("FAIL dir_reach5 got %0d want 5", c_a); else passed++;
    up = 1'b0;
    tick();
    total++; if (c_a !== 4'd4) $display("FAIL dir_down_from5 got %0d want 4", c_a); else passed++;
    total++; if (wrap_a !== 1'b0) $display("FAIL dir_down_nowrap got %0b want 0", wrap_a); else passed++;
    total++; if (wcnt_a !== 8'd2) $display("FAIL dir_wcnt got %0d want 2", wcnt_a); else passed++;
    en = 1'b0;
  endtask

  task automatic test_load();
    apply_reset();
    ld = 1'b1; ld_val = 4'd9;
    tick();
    total++; if (c_a !== 4'd9) $display("FAIL load9_count got %0d want 9", c_a); else passed++;
    total++; if (lderr_a !== 1'b0) $display("FAIL load9_err got %0b want 0", lderr_a); else passed++;
    ld_val = 4'd15;
    tick();
    total++; if (c_a !== 4'd13) $display("FAIL load15_clamp got %0d want 13", c_a); else passed++;
    total++; if (lderr_a !== 1'b1) $display("FAIL load15_err got %0b want 1", lderr_a); else passed++;
    ld = 1'b0;
    tick();
    total++; if (c_a !== 4'd13) $display("FAIL load_hold got %0d want 13", c_a); else passed++;
    total++; if (lderr_a !== 1'b0) $display("FAIL load_err_oneshot got %0b want 0", lderr_a); else passed++;
    ld = 1'b1; ld_val = 4'd4; en = 1'b1; up = 1'b1;
    #1;
    total++; if (tc_a !== 1'b1) $display("FAIL load_tc_at13 got %0b want 1", tc_a); else passed++;
    tick();
    total++; if (c_a !== 4'd4) $display("FAIL load_over_en got %0d want 4", c_a); else passed++;
    total++; if (wrap_a !== 1'b0) $display("FAIL load_nowrap got %0b want 0", wrap_a); else passed++;
    total++; if (wcnt_a !== 8'd0) $display("FAIL load_wcnt got %0d want 0", wcnt_a); else passed++;
    ld = 1'b0; en = 1'b0;
  endtask

  task automatic test_priority();
    apply_reset();
    up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ld = 1'b1; ld_val = 4'd0; en = 1'b0;
      tick();
      ld = 1'b0; en = 1'b1;
      tick();
    end
    en = 1'b0; ld = 1'b1; ld_val = 4'd7;
    tick();
    ld = 1'b0;
    total++; if (c_a !== 4'd7) $display("FAIL prio_setup_count got %0d want 7", c_a); else passed++;
    total++; if (wcnt_a !== 8'd5) $display("FAIL prio_setup_wcnt got %0d want 5", wcnt_a); else passed++;
    sclr = 1'b1; ld = 1'b1; ld_val = 4'd15; en = 1'b1; up = 1'b1;
    tick();
    total++; if (c_a !== 4'd0) $display("FAIL sclr_count got %0d want 0", c_a); else passed++;
    total++; if (wcnt_a !== 8'd0) $display("FAIL sclr_wcnt got %0d want 0", wcnt_a); else passed++;
    total++; if (lderr_a !== 1'b0) $display("FAIL sclr_lderr got %0b want 0", lderr_a); else passed++;
    total++; if (wrap_a !== 1'b0) $display("FAIL sclr_wrap got %0b want 0", wrap_a); else passed++;
    sclr = 1'b0; ld = 1'b1; ld_val = 4'd9; en = 1'b0;
    tick();
    ld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      up = (i % 2 == 0);
      #1;
      total++; if (tc_a !== 1'b0) $display("FAIL hold_tc cycle %0d got %0b want 0", i, tc_a); else passed++;
      tick();
      total++; if (c_a !== 4'd9) $display("FAIL hold_count cycle %0d got %0d want 9", i, c_a); else passed++;
    end
  endtask

  task automatic test_saturation();
    int w = 0;
    apply_reset();
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 70; i++) begin
      tick();
      if ((i + 1) % 14 == 0) begin
        w++;
        total++; if (wcnt_s !== 2'((w > 3) ? 3 : w)) $display("FAIL sat_wcnt wrap %0d got %0d want %0d", w, wcnt_s, (w > 3) ? 3 : w); else passed++;
        total++; if (wrap_s !== 1'b1) $display("FAIL sat_wrap wrap %0d got %0b want 1", w, wrap_s); else passed++;
      end
    end
    total++; if (wcnt_s !== 2'd3) $display("FAIL sat_final got %0d want 3", wcnt_s); else passed++;
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    en = 1'b1; up = 1'b1;
    repeat (6) tick();
    total++; if (c_a !== 4'd6) $display("FAIL mid_setup got %0d want 6", c_a); else passed++;
    #2;
    rstn = 1'b0;
    #1;
    total++; if (c_a !== 4'd0) $display("FAIL mid_async_count got %0d want 0", c_a); else passed++;
    total++; if (wrap_a !== 1'b0) $display("FAIL mid_async_wrap got %0b want 0", wrap_a); else passed++;
    tick();
    total++; if (c_a !== 4'd0) $display("FAIL mid_held_count got %0d want 0", c_a); else passed++;
    rstn = 1'b1;
    tick();
    total++; if (c_a !== 4'd1) $display("FAIL mid_resume got %0d want 1", c_a); else passed++;
    total++; if (wrap_a !== 1'b0) $display("FAIL mid_resume_wrap got %0b want 0", wrap_a); else passed++;
    en = 1'b0;
  endtask

  task automatic test_mod16();
    int   exp_c = 0;
    logic wr;
    apply_reset();
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 17; i++) begin
      #1;
      total++; if (tc_m !== (exp_c == 15)) $display("FAIL m16_tc step %0d got %0b want %0b", i, tc_m, (exp_c == 15)); else passed++;
      tick();
      wr = (exp_c == 15);
      exp_c = (exp_c + 1) % 16;
      total++; if (c_m !== 4'(exp_c)) $display("FAIL m16_count step %0d got %0d want %0d", i, c_m, exp_c); else passed++;
      total++; if (wrap_m !== wr) $display("FAIL m16_wrap step %0d got %0b want %0b", i, wrap_m, wr); else passed++;
    end
    total++; if (wcnt_m !== 8'd1) $display("FAIL m16_wcnt got %0d want 1", wcnt_m); else passed++;
    en = 1'b0;
  endtask

  task automatic test_mod2();
    int exp_c = 1;
    apply_reset();
    total++; if (c_2 !== 4'd1) $display("FAIL m2_reset got %0d want 1", c_2); else passed++;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up = (exp_c == 1);
      #1;
      total++; if (tc_2 !== 1'b1) $display("FAIL m2_tc step %0d got %0b want 1", i, tc_2); else passed++;
      tick();
      exp_c = 1 - exp_c;
      total++; if (c_2 !== 4'(exp_c)) $display("FAIL m2_count step %0d got %0d want %0d", i, c_2, exp_c); else passed++;
      total++; if (wrap_2 !== 1'b1) $display("FAIL m2_wrap step %0d got %0b want 1", i, wrap_2); else passed++;
    end
    total++; if (wcnt_2 !== 8'd4) $display("FAIL m2_wcnt got %0d want 4", wcnt_2); else passed++;
    up = 1'b0;
    #1;
    total++; if (tc_2 !== 1'b0) $display("FAIL m2_down_tc got %0b want 0", tc_2); else passed++;
    tick();
    total++; if (c_2 !== 4'd0) $display("FAIL m2_down_count got %0d want 0", c_2); else passed++;
    total++; if (wrap_2 !== 1'b0) $display("FAIL m2_down_wrap got %0b want 0", wrap_2); else passed++;
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_dir();
    test_load();
    test_priority();
    test_saturation();
    test_reset_mid();
    test_mod16();
    test_mod2();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
